// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Holds the state enum, opcode/funct constants, datapath select codes and trap causes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Maps the decoded instruction to the first execute-phase state; anything unsupported traps.
    function automatic state_t decode_dispatch(input logic [5:0] opcode, input logic [5:0] funct);
        state_t target;
        case (opcode)
            OP_RTYPE: target = (funct == FUNCT_ADD) ? S_EXEC_R : S_TRAP;
            OP_ADDI:  target = S_EXEC_I;
            OP_LW:    target = S_ADDR;
            OP_SW:    target = S_ADDR;
            OP_BEQ:   target = S_BRANCH;
            OP_BNE:   target = S_BRANCH;
            OP_J:     target = S_JUMP;
            default:  target = S_TRAP;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive wait cycles of an outstanding memory request and flags a timeout.
// A MEM_TIMEOUT of 0 disables the expiry flag entirely.
module mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] count;

    // Saturates at the limit so a held request never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst || !active || done) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && active && !done && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the 32-bit MIPS core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and arbitrates the single memory port.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state;
    state_t     next_state;
    logic [1:0] cause_q;
    logic [1:0] next_cause;
    logic       mem_active;
    logic       expired;

    // Derived from state alone so the timer input never depends on its own expiry output.
    assign mem_active = !rst && ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR));

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (mem_active),
        .done   (mem_ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            cause_q <= TRAP_NONE;
        end else begin
            state   <= next_state;
            cause_q <= next_cause;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = cause_q;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b  = SRC_B_IMM_SH2;
                next_state = decode_dispatch(opcode, funct);
                if (next_state == S_TRAP) begin
                    next_cause = TRAP_ILLEGAL;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_RT;
                alu_op     = ALU_FUNCT;
                next_state = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_WB_MEM;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            // Branch outcome is a Mealy term: the ALU subtract result settles within this cycle.
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_RT;
                alu_op     = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset silences the port immediately, including a request still awaiting mem_ready.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven, scoreboard-checked bench for multicycle_ctrl: one row per clock cycle
// giving the inputs and the complete expected output vector.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        logic       mem_ready;
        out_t       exp;
        string      name;
    } vec_t;

    //                           req  we   iord irw  pcw  pcsrc  srca srcb   aluop  rw   rdst m2r  done trap cause
    localparam out_t E_ZERO     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_F_WAIT   = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_F_GO     = '{1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_DECODE   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_EXEC_R   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_WB_R     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_EXEC_I   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_WB_I     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_MEM_RD   = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_WB_MEM   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00};
    localparam out_t E_WR_WAIT  = '{1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    localparam out_t E_WR_GO    = '{1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_BR_TAKE  = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_BR_NOT   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_JUMP     = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00};
    localparam out_t E_TRAP_ILL = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01};
    localparam out_t E_TRAP_TO  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10};

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ILL   = 6'b111111;
    localparam logic [5:0] T_ADD   = 6'b100000;
    localparam logic [5:0] T_SUB   = 6'b100010;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
    out_t       actual;

    vec_t       vectors[$];
    out_t       expQ[$];
    string      nameQ[$];
    int         checkCount = 0;
    int         errorCount = 0;

    multicycle_ctrl #(
        .MEM_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .instr_done(instr_done),
        .trap      (trap),
        .trap_cause(trap_cause)
    );

    assign actual = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done,
                     trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addRows(input int n, input logic r, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic mr, input out_t e, input string nm);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst       = r;
            v.opcode    = op;
            v.funct     = fn;
            v.zero      = z;
            v.mem_ready = mr;
            v.exp       = e;
            v.name      = nm;
            vectors.push_back(v);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        opcode    = v.opcode;
        funct     = v.funct;
        zero      = v.zero;
        mem_ready = v.mem_ready;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
    endtask

    task automatic checkOutput(input int row);
        out_t  e;
        string nm;
        checkCount++;
        if (expQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboard_empty row %0d: no expected entry", row);
        end else begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            if (actual !== e) begin
                errorCount++;
                $display("[TB] FAIL %s row %0d: got %05h expected %05h", nm, row, actual, e);
            end
        end
    endtask

    task automatic checkValue(input string nm, input int got, input int want);
        checkCount++;
        if (got != want) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        int trapCycles;
        int doneCycles;

        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        addRows(2, 1, T_RTYPE, T_ADD, 0, 1, E_ZERO, "reset");
        // add, zero wait
        addRows(1, 0, T_RTYPE, T_ADD, 0, 1, E_F_GO,   "add_fetch");
        addRows(1, 0, T_RTYPE, T_ADD, 0, 1, E_DECODE, "add_decode");
        addRows(1, 0, T_RTYPE, T_ADD, 0, 1, E_EXEC_R, "add_exec");
        addRows(1, 0, T_RTYPE, T_ADD, 0, 1, E_WB_R,   "add_wb");
        // addi
        addRows(1, 0, T_ADDI, 6'd0, 0, 1, E_F_GO,   "addi_fetch");
        addRows(1, 0, T_ADDI, 6'd0, 0, 1, E_DECODE, "addi_decode");
        addRows(1, 0, T_ADDI, 6'd0, 0, 1, E_EXEC_I, "addi_exec");
        addRows(1, 0, T_ADDI, 6'd0, 0, 1, E_WB_I,   "addi_wb");
        // lw with three data wait states
        addRows(1, 0, T_LW, 6'd0, 0, 1, E_F_GO,   "lw_fetch");
        addRows(1, 0, T_LW, 6'd0, 0, 1, E_DECODE, "lw_decode");
        addRows(1, 0, T_LW, 6'd0, 0, 1, E_EXEC_I, "lw_addr");
        addRows(3, 0, T_LW, 6'd0, 0, 0, E_MEM_RD, "lw_rd_wait");
        addRows(1, 0, T_LW, 6'd0, 0, 1, E_MEM_RD, "lw_rd_ready");
        addRows(1, 0, T_LW, 6'd0, 0, 1, E_WB_MEM, "lw_wb");
        // sw, zero wait
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_F_GO,   "sw_fetch");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_DECODE, "sw_decode");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_EXEC_I, "sw_addr");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_WR_GO,  "sw_write");
        // branches: all four opcode/zero combinations
        addRows(1, 0, T_BEQ, 6'd0, 1, 1, E_F_GO,    "beq1_fetch");
        addRows(1, 0, T_BEQ, 6'd0, 1, 1, E_DECODE,  "beq1_decode");
        addRows(1, 0, T_BEQ, 6'd0, 1, 1, E_BR_TAKE, "beq_zero1");
        addRows(1, 0, T_BEQ, 6'd0, 0, 1, E_F_GO,    "beq0_fetch");
        addRows(1, 0, T_BEQ, 6'd0, 0, 1, E_DECODE,  "beq0_decode");
        addRows(1, 0, T_BEQ, 6'd0, 0, 1, E_BR_NOT,  "beq_zero0");
        addRows(1, 0, T_BNE, 6'd0, 1, 1, E_F_GO,    "bne1_fetch");
        addRows(1, 0, T_BNE, 6'd0, 1, 1, E_DECODE,  "bne1_decode");
        addRows(1, 0, T_BNE, 6'd0, 1, 1, E_BR_NOT,  "bne_zero1");
        addRows(1, 0, T_BNE, 6'd0, 0, 1, E_F_GO,    "bne0_fetch");
        addRows(1, 0, T_BNE, 6'd0, 0, 1, E_DECODE,  "bne0_decode");
        addRows(1, 0, T_BNE, 6'd0, 0, 1, E_BR_TAKE, "bne_zero0");
        // j after two fetch wait states
        addRows(2, 0, T_J, 6'd0, 0, 0, E_F_WAIT, "j_fetch_wait");
        addRows(1, 0, T_J, 6'd0, 0, 1, E_F_GO,   "j_fetch");
        addRows(1, 0, T_J, 6'd0, 0, 1, E_DECODE, "j_decode");
        addRows(1, 0, T_J, 6'd0, 0, 1, E_JUMP,   "j_jump");
        // reset during the MEM_WR wait
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_F_GO,    "swrst_fetch");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_DECODE,  "swrst_decode");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_EXEC_I,  "swrst_addr");
        addRows(2, 0, T_SW, 6'd0, 0, 0, E_WR_WAIT, "swrst_wait");
        addRows(1, 1, T_SW, 6'd0, 0, 0, E_ZERO,    "swrst_abort");
        addRows(1, 0, T_SW, 6'd0, 0, 0, E_F_WAIT,  "swrst_refetch");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_F_GO,    "swrst_fetch2");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_DECODE,  "swrst_decode2");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_EXEC_I,  "swrst_addr2");
        addRows(1, 0, T_SW, 6'd0, 0, 1, E_WR_GO,   "swrst_write2");
        // R-type with unsupported funct, then illegal opcode
        addRows(1, 0, T_RTYPE, T_SUB, 0, 1, E_F_GO,     "badfn_fetch");
        addRows(1, 0, T_RTYPE, T_SUB, 0, 1, E_DECODE,   "badfn_decode");
        addRows(3, 0, T_RTYPE, T_SUB, 0, 1, E_TRAP_ILL, "badfn_trap");
        addRows(1, 1, T_RTYPE, T_SUB, 0, 1, E_ZERO,     "badfn_reset");
        addRows(1, 0, T_ILL, 6'd0, 0, 1, E_F_GO,     "ill_fetch");
        addRows(1, 0, T_ILL, 6'd0, 0, 1, E_DECODE,   "ill_decode");
        addRows(2, 0, T_ILL, 6'd0, 0, 1, E_TRAP_ILL, "ill_trap");
        addRows(1, 1, T_ILL, 6'd0, 0, 1, E_ZERO,     "ill_reset");
        // fetch timeout: 16 waiting cycles, then trap
        addRows(16, 0, T_J, 6'd0, 0, 0, E_F_WAIT,  "fto_wait");
        addRows(2,  0, T_J, 6'd0, 0, 0, E_TRAP_TO, "fto_trap");
        addRows(1,  1, T_J, 6'd0, 0, 0, E_ZERO,    "fto_reset");
        // mem_ready in the cycle the counter reaches the limit wins
        addRows(15, 0, T_J, 6'd0, 0, 0, E_F_WAIT, "fedge_wait");
        addRows(1,  0, T_J, 6'd0, 0, 1, E_F_GO,   "fedge_ready");
        addRows(1,  0, T_J, 6'd0, 0, 1, E_DECODE, "fedge_decode");
        addRows(1,  0, T_J, 6'd0, 0, 1, E_JUMP,   "fedge_jump");
        // data-read timeout
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_F_GO,    "dto_fetch");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_DECODE,  "dto_decode");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_EXEC_I,  "dto_addr");
        addRows(16, 0, T_LW, 6'd0, 0, 0, E_MEM_RD,  "dto_wait");
        addRows(2,  0, T_LW, 6'd0, 0, 0, E_TRAP_TO, "dto_trap");
        addRows(1,  1, T_LW, 6'd0, 0, 0, E_ZERO,    "dto_reset");
        // data-read boundary: ready at the limit cycle
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_F_GO,   "dedge_fetch");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_DECODE, "dedge_decode");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_EXEC_I, "dedge_addr");
        addRows(15, 0, T_LW, 6'd0, 0, 0, E_MEM_RD, "dedge_wait");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_MEM_RD, "dedge_ready");
        addRows(1,  0, T_LW, 6'd0, 0, 1, E_WB_MEM, "dedge_wb");
        addRows(1,  0, T_LW, 6'd0, 0, 0, E_F_WAIT, "dedge_refetch");

        foreach (vectors[i]) begin
            @(negedge clk);
            applyStimulus(vectors[i]);
            #1;
            checkOutput(i);
        end

        // Trap stays sticky for as long as reset is withheld, with no retirement.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; opcode = T_ILL; funct = 6'd0; mem_ready = 1'b1;
        trapCycles = 0;
        doneCycles = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (trap) trapCycles++;
            if (instr_done) doneCycles++;
            @(negedge clk);
        end
        checkValue("sticky_trap_cycles", trapCycles, 10);
        checkValue("sticky_done_cycles", doneCycles, 1 - 1);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 32-bit MIPS core, replacing per-instruction static decode with a Moore/Mealy state machine that steps the shared datapath through fetch, decode, execute, memory and writeback. It owns the single memory port, arbitrating it between instruction fetch and load/store data access through a req/ready handshake. It supports the core subset `add`, `addi`, `lw`, `sw`, `j`, `beq` and `bne`, and traps on illegal opcodes or memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles with `mem_req` high and no `mem_ready`. A value of 0 disables the timeout.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `opcode`, in, 6: IR[31:26]. Stable from DECODE until the next `ir_write`.
- `funct`, in, 6: IR[5:0].
- `zero`, in, 1: ALU zero flag.
- `mem_ready`, in, 1: memory completes the current request this cycle.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: write when 1.
- `iord`, out, 1: address select. 0 = PC, 1 = ALUOut.
- `ir_write`, out, 1: load IR.
- `pc_write`, out, 1: load PC.
- `pc_src`, out, 2: PC source. 00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target.
- `alu_src_a`, out, 1: ALU A select. 0 = PC, 1 = rs.
- `alu_src_b`, out, 2: ALU B select. 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_op`, out, 2: ALU operation. 00 = add, 01 = sub, 10 = funct-decoded.
- `reg_write`, out, 1: register file write enable.
- `reg_dst`, out, 1: destination select. 1 = rd, 0 = rt.
- `mem_to_reg`, out, 1: writeback source is MDR.
- `instr_done`, out, 1: one-cycle pulse when an instruction retires.
- `trap`, out, 1: sticky; set on entering TRAP.
- `trap_cause`, out, 2: 01 = illegal opcode, 10 = memory timeout.

## Operation
- **Reset:**
  - While `rst` is high, every output is forced to 0 and the wait counter clears.
  - State goes to FETCH; `trap_cause` goes to 00.
- **FETCH:**
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - When `mem_ready` is high: `ir_write`=1 and `pc_write`=1 in that same cycle, then go to DECODE.
- **DECODE:**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. This precomputes the branch target.
  - Dispatch on opcode:
    - 000000 with funct 100000 → EXEC_R.
    - 001000 → EXEC_I.
    - 100011 or 101011 → ADDR.
    - 000100 or 000101 → BRANCH.
    - 000010 → JUMP.
    - Any other value → TRAP with cause 01. This includes R-type with any other funct.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → WB_R.
- **WB_R:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1 → FETCH.
- **EXEC_I:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → WB_I.
- **WB_I:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1 → FETCH.
- **ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_RD for `lw`, MEM_WR for `sw`.
- **MEM_RD:** `mem_req`=1, `iord`=1, `mem_we`=0. Advance to WB_MEM on `mem_ready`.
- **WB_MEM:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1 → FETCH.
- **MEM_WR:**
  - Outputs: `mem_req`=1, `iord`=1, `mem_we`=1.
  - On `mem_ready`: `instr_done`=1, then go to FETCH.
- **BRANCH:**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `instr_done`=1.
  - `pc_write` = (beq & `zero`) | (bne & ~`zero`). This is a Mealy term on `zero`.
  - Next state: FETCH.
- **JUMP:** `pc_src`=10, `pc_write`=1, `instr_done`=1 → FETCH.
- **TRAP:** all datapath outputs are 0; `trap`=1. Exit only via `rst`.
- **Unlisted outputs** are 0 in every state.

## Timing
- **Zero-wait latencies** (cycles from FETCH entry to retire):
  - `add`, `addi`, `sw`: 4.
  - `lw`: 5.
  - `beq`, `bne`, `j`: 3.
- **Wait states:** each cycle `mem_ready` is low adds one cycle. Outputs are held constant throughout the wait.
- **Memory handshake:**
  - `mem_req` stays high until the cycle `mem_ready` is sampled high.
  - `mem_req` drops in the following state.
  - `mem_ready` is ignored when `mem_req` is 0.
- **Wait counter:**
  - Increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - Clears on `mem_ready` and on state change.
  - Counter == `MEM_TIMEOUT` with `mem_ready` still low → TRAP with cause 10 on the next edge.
  - `mem_ready` arriving in the same cycle the counter hits the limit wins: no trap.
- **Reset mid-operation:** `rst` in any state, including mid-handshake, aborts on the next edge. The pending `mem_req` drops immediately.
- `instr_done` never asserts in the same cycle as `trap`.

## Structure
- **Package `mips_ctrl_pkg`** holds:
  - the state enum;
  - opcode and funct constants;
  - `alu_op`, `pc_src` and `alu_src_b` encodings;
  - `trap_cause` codes.
- **Sub-module `mem_wait_timer`:** the parameterised wait counter with inputs `clk`, `rst`, `active`, `done` and output `expired`.
- **FSM coding:** state register plus a combinational next-state/output block.

## Test plan
- **Zero-wait `add`:** reset, then `mem_ready`=1 always, opcode/funct 000000/100000 → `ir_write`+`pc_write` at cycle 1, `reg_write`=1 with `reg_dst`=1 at cycle 4, `instr_done` pulse once.
- **`lw` with 3 wait cycles on the data access:** `mem_req`=1, `iord`=1 for 4 cycles, then WB_MEM with `mem_to_reg`=1. Total latency 8.
- **`beq`:** `zero`=1 → `pc_write`=1, `pc_src`=01. `bne` with `zero`=1 → `pc_write`=0. Both retire in 3 cycles.
- **Illegal opcode 111111:** DECODE → TRAP. `trap`=1, `trap_cause`=01, all outputs 0 until `rst`.
- **`MEM_TIMEOUT`=15 with `mem_ready` never asserting in FETCH:** TRAP with cause 10 after 16 cycles. A second run with `mem_ready` arriving at exactly the 15th wait cycle → no trap.
- **`rst` asserted during MEM_WR wait:** all outputs 0 next cycle, FETCH after release, no stray `mem_we`.
